// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the ahb_s responder: transfer encodings, response codes and FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never touch the slave.
    function automatic logic is_active(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_s_mem.sv
// Word-organised storage for ahb_s: byte-enable synchronous write, asynchronous read.
module ahb_s_mem #(
    parameter  int DATAW     = 32,
    parameter  int MEM_DEPTH = 256,
    localparam int AW        = $clog2(MEM_DEPTH),
    localparam int BYTES     = DATAW / 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [BYTES-1:0] be,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [MEM_DEPTH];

    // NOTE: the array deliberately has no reset; contents survive a bus reset and a reset loop would not map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_s.sv
// AHB-Lite responder: address-phase capture, legality check, wait-state FSM and byte-lane memory access.
module ahb_s
    import ahb_pkg::*;
#(
    parameter int ADDRW       = 32,
    parameter int DATAW       = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel,
    input  logic [ADDRW-1:0] haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic [DATAW-1:0] hwdata,
    input  logic             hready,
    output logic             hreadyout,
    output logic             hresp,
    output logic [DATAW-1:0] hrdata
);

    localparam int BYTES  = DATAW / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int AQ_W   = LANE_W + MEM_AW;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDRW:0] MEM_BYTES = (ADDRW+1)'(MEM_DEPTH * BYTES);
    localparam logic [2:0]     MAX_SIZE  = 3'(LANE_W);

    state_t           state_q, state_d;
    logic [AQ_W-1:0]  addr_q;
    logic [2:0]       size_q;
    logic             write_q;
    logic [CNT_W-1:0] wait_cnt;

    logic              ready_state, accept, acc_err;
    logic [LANE_W-1:0] align_mask;
    logic [BYTES-1:0]  be;
    logic              mem_we;
    logic [DATAW-1:0]  mem_rdata;

    // Burst type is informational only: the master computes every address.
    logic unused_burst;
    assign unused_burst = ^hburst;

    // A new address phase is only taken in states that are completing (hreadyout=1).
    assign ready_state = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept      = hsel && hready && is_active(htrans_t'(htrans)) && ready_state;

    assign align_mask = LANE_W'((32'd1 << hsize) - 32'd1);
    assign acc_err    = (hsize > MAX_SIZE)
                     || (|(haddr[LANE_W-1:0] & align_mask))
                     || ({1'b0, haddr} >= MEM_BYTES);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!accept)               state_d = ST_IDLE;
                else if (acc_err)          state_d = ST_ERR1;
                else if (WAIT_CYCLES > 0)  state_d = ST_WAIT;
                else                       state_d = ST_DATA;
            end
            ST_WAIT: if (wait_cnt == CNT_W'(1)) state_d = ST_DATA;
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
        hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        hrdata    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            wait_cnt <= '0;
        end else if (accept) begin
            addr_q   <= haddr[AQ_W-1:0];
            size_q   <= hsize;
            write_q  <= hwrite;
            wait_cnt <= CNT_W'(WAIT_CYCLES);
        end else if (state_q == ST_WAIT) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Little-endian lanes: a lane is enabled when it falls in the same hsize-aligned chunk as the address.
    always_comb begin
        be = '0;
        for (int b = 0; b < BYTES; b++) begin
            be[b] = ((b >> size_q) == (int'(addr_q[LANE_W-1:0]) >> size_q));
        end
    end

    assign mem_we = (state_q == ST_DATA) && write_q;

    ahb_s_mem #(
        .DATAW     (DATAW),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[AQ_W-1:LANE_W]),
        .be    (be),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_s.sv
// Bench for ahb_s: a zero-wait and a one-wait instance checked every cycle against a transfer-level bus model.
module tb_ahb_s;
    import ahb_pkg::*;

    localparam int MEMB = 1024;
    localparam int MAXB = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=0 instance, index 1: WAIT_CYCLES=1 instance.
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    ahb_s #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
        .hready(hreadyout[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_s #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
        .hready(hreadyout[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- transfer-level model ----------------
    typedef enum {PH_NONE, PH_OK, PH_ERR} ph_kind_t;
    ph_kind_t   ph_kind  [2];
    int         ph_cycle [2];
    logic       ph_write [2];
    int         ph_addr  [2];
    int         ph_size  [2];
    logic [7:0] mbyte    [2][MEMB];
    bit         mknown   [2][MEMB];

    task automatic model_step(input int i);
        logic        exp_ro, exp_resp;
        logic [31:0] exp_rd, mask;
        int          base, a;
        exp_rd = '0;
        mask   = 32'hFFFF_FFFF;
        if (!rst) begin
            ph_kind[i] = PH_NONE;
            check($sformatf("u%0d reset hreadyout", i), 32'(hreadyout[i]), 32'd1);
            check($sformatf("u%0d reset hresp", i), 32'(hresp[i]), 32'd0);
            check($sformatf("u%0d reset hrdata", i), hrdata[i], 32'd0);
            return;
        end
        case (ph_kind[i])
            PH_ERR: begin
                exp_ro   = (ph_cycle[i] == 1);
                exp_resp = 1'b1;
            end
            PH_OK: begin
                exp_ro   = (ph_cycle[i] >= i);
                exp_resp = 1'b0;
                if (exp_ro && !ph_write[i]) begin
                    base = ph_addr[i] & ~3;
                    for (int b = 0; b < 4; b++) begin
                        exp_rd[8*b +: 8] = mbyte[i][base+b];
                        if (!mknown[i][base+b]) mask[8*b +: 8] = 8'h00;
                    end
                end
            end
            default: begin
                exp_ro   = 1'b1;
                exp_resp = 1'b0;
            end
        endcase
        check($sformatf("u%0d hreadyout", i), 32'(hreadyout[i]), 32'(exp_ro));
        check($sformatf("u%0d hresp", i), 32'(hresp[i]), 32'(exp_resp));
        check($sformatf("u%0d hrdata", i), hrdata[i] & mask, exp_rd & mask);

        if (exp_ro) begin
            if (ph_kind[i] == PH_OK && ph_write[i]) begin
                for (int b = 0; b < (1 << ph_size[i]); b++) begin
                    a = ph_addr[i] + b;
                    mbyte[i][a]  = hwdata[i][8*(a%4) +: 8];
                    mknown[i][a] = 1'b1;
                end
            end
            if (hsel[i] && htrans[i][1]) begin
                ph_addr[i]  = int'(haddr[i]);
                ph_size[i]  = int'(hsize[i]);
                ph_write[i] = hwrite[i];
                ph_cycle[i] = 0;
                if (ph_addr[i] >= MEMB || ph_size[i] > 2 || (ph_addr[i] % (1 << ph_size[i])) != 0)
                    ph_kind[i] = PH_ERR;
                else
                    ph_kind[i] = PH_OK;
            end else begin
                ph_kind[i] = PH_NONE;
            end
        end else begin
            ph_cycle[i]++;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- pipelined bus driver ----------------
    logic        bt_sel   [MAXB];
    logic [1:0]  bt_trans [MAXB];
    logic [31:0] bt_addr  [MAXB];
    logic        bt_write [MAXB];
    logic [2:0]  bt_size  [MAXB];
    logic [31:0] bt_wdata [MAXB];
    logic [31:0] obs_rdata[MAXB];
    logic        obs_resp [MAXB];
    int          obs_wait [MAXB];
    int          nb = 0;
    logic [2:0]  cur_burst = 3'b001;

    task automatic add_beat(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                            input logic write, input logic [2:0] size, input logic [31:0] wdata);
        bt_sel[nb]   = sel;
        bt_trans[nb] = trans;
        bt_addr[nb]  = addr;
        bt_write[nb] = write;
        bt_size[nb]  = size;
        bt_wdata[nb] = wdata;
        nb++;
    endtask

    // Starts #1 after a posedge; each address phase overlaps the previous beat's data phase.
    task automatic run_seq(input int i);
        int waits;
        for (int k = 0; k <= nb; k++) begin
            if (k < nb) begin
                hsel[i]   = bt_sel[k];
                htrans[i] = bt_trans[k];
                haddr[i]  = bt_addr[k];
                hwrite[i] = bt_write[k];
                hsize[i]  = bt_size[k];
            end else begin
                hsel[i]   = 1'b0;
                htrans[i] = HTRANS_IDLE;
            end
            hburst[i] = cur_burst;
            hwdata[i] = (k > 0) ? bt_wdata[k-1] : 32'd0;
            waits = 0;
            @(negedge clk);
            while (!hreadyout[i] && waits < 50) begin
                waits++;
                @(negedge clk);
            end
            if (waits >= 50) begin
                check($sformatf("u%0d hready timeout", i), 32'(hreadyout[i]), 32'd1);
                break;
            end
            if (k > 0) begin
                obs_rdata[k-1] = hrdata[i];
                obs_resp[k-1]  = hresp[i];
                obs_wait[k-1]  = waits;
            end
            @(posedge clk);
            #1;
        end
        nb = 0;
    endtask

    function automatic logic [31:0] bdata(input logic [31:0] addr);
        return 32'hA500_0000 | addr;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = HTRANS_IDLE; hwrite[i] = 1'b0;
            hsize[i] = HSIZE_WORD; hburst[i] = 3'b000; hwdata[i] = '0;
            ph_kind[i] = PH_NONE; ph_cycle[i] = 0;
        end

        // Reset held for two cycles, then released onto an idle bus.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d por hreadyout", i), 32'(hreadyout[i]), 32'd1);
            check($sformatf("u%0d por hresp", i), 32'(hresp[i]), 32'd0);
            check($sformatf("u%0d por hrdata", i), hrdata[i], 32'd0);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // One-wait word write then read-back of the same word.
        add_beat(1, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD, 32'hDEAD_BEEF);
        add_beat(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD, 32'h0);
        run_seq(1);
        check("w1 write waits", 32'(obs_wait[0]), 32'd1);
        check("w1 read waits", 32'(obs_wait[1]), 32'd1);
        check("w1 read data", obs_rdata[1], 32'hDEAD_BEEF);
        check("w1 read resp", 32'(obs_resp[1]), 32'd0);

        // Byte lane merge, then a misaligned halfword.
        add_beat(1, HTRANS_NONSEQ, 32'h10, 1, HSIZE_WORD, 32'h1122_3344);
        add_beat(1, HTRANS_NONSEQ, 32'h13, 1, HSIZE_BYTE, 32'hAA00_0000);
        add_beat(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_NONSEQ, 32'h11, 0, HSIZE_HALF, 32'h0);
        run_seq(1);
        check("byte merge data", obs_rdata[2], 32'hAA22_3344);
        check("model word 0x10", {mbyte[1][19], mbyte[1][18], mbyte[1][17], mbyte[1][16]}, 32'hAA22_3344);
        check("misaligned half resp", 32'(obs_resp[3]), 32'd1);
        check("misaligned half err cycles", 32'(obs_wait[3]), 32'd1);

        // Out-of-range read, erroring write, memory left intact.
        add_beat(1, HTRANS_NONSEQ, 32'h400, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_NONSEQ, 32'h12, 1, HSIZE_WORD, 32'hFFFF_FFFF);
        add_beat(1, HTRANS_NONSEQ, 32'h10, 0, HSIZE_WORD, 32'h0);
        run_seq(1);
        check("oob read resp", 32'(obs_resp[0]), 32'd1);
        check("bad write resp", 32'(obs_resp[1]), 32'd1);
        check("after errors data", obs_rdata[2], 32'hAA22_3344);
        check("after errors resp", 32'(obs_resp[2]), 32'd0);

        // Zero-wait INCR4 write and read back, each with a BUSY mid-burst.
        cur_burst = 3'b011;
        add_beat(1, HTRANS_NONSEQ, 32'h20, 1, HSIZE_WORD, bdata(32'h20));
        add_beat(1, HTRANS_SEQ,    32'h24, 1, HSIZE_WORD, bdata(32'h24));
        add_beat(1, HTRANS_BUSY,   32'h28, 1, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_SEQ,    32'h28, 1, HSIZE_WORD, bdata(32'h28));
        add_beat(1, HTRANS_SEQ,    32'h2C, 1, HSIZE_WORD, bdata(32'h2C));
        add_beat(1, HTRANS_NONSEQ, 32'h20, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_SEQ,    32'h24, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_BUSY,   32'h28, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_SEQ,    32'h28, 0, HSIZE_WORD, 32'h0);
        add_beat(1, HTRANS_SEQ,    32'h2C, 0, HSIZE_WORD, 32'h0);
        run_seq(0);
        for (int k = 0; k < 10; k++) check($sformatf("burst beat %0d waits", k), 32'(obs_wait[k]), 32'd0);
        check("burst rd 0x20", obs_rdata[5], 32'hA500_0020);
        check("burst rd 0x24", obs_rdata[6], 32'hA500_0024);
        check("burst rd 0x28", obs_rdata[8], 32'hA500_0028);
        check("burst rd 0x2C", obs_rdata[9], 32'hA500_002C);
        cur_burst = 3'b001;

        // Reset during the wait state of a write: write is dropped.
        add_beat(1, HTRANS_NONSEQ, 32'h40, 1, HSIZE_WORD, 32'h1234_5678);
        run_seq(1);
        hsel[1] = 1'b1; haddr[1] = 32'h40; htrans[1] = HTRANS_NONSEQ;
        hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid-write hreadyout", 32'(hreadyout[1]), 32'd0);
        hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE; hwdata[1] = 32'hCAFE_F00D;
        rst = 1'b0;
        #1;
        check("async reset hreadyout", 32'(hreadyout[1]), 32'd1);
        check("async reset hresp", 32'(hresp[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        add_beat(1, HTRANS_NONSEQ, 32'h40, 0, HSIZE_WORD, 32'h0);
        run_seq(1);
        check("post-reset read 0x40", obs_rdata[0], 32'h1234_5678);

        // Randomised traffic on both instances, checked cycle by cycle by the model.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 60; k++) begin
                logic [31:0] a;
                logic [2:0]  s;
                a = ($urandom % 16 == 0) ? 32'h400 + ($urandom % 16) : 32'($urandom_range(0, MEMB-1));
                s = ($urandom % 8 == 0) ? 3'b011 : 3'($urandom % 3);
                if ($urandom % 3 != 0) a = a & ~((32'd1 << s) - 32'd1);
                add_beat(($urandom % 8) != 0, 2'($urandom % 4), a, 1'($urandom % 2), s, $urandom);
            end
            run_seq(i);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
